sum1b_primitive_core: RTL and testbench

- 1-bit full adder built from Verilog gate primitives (xor/and/or instances only, no behavioural arithmetic).
- Purely combinational sum/carry path, plus a clocked register stage.
- Optional bit-serial mode feeds the registered carry back as carry-in, so the cell can add multi-bit operands one bit per cycle.
- Leaf arithmetic cell for the processor datapath exercises. Compatible with 1 ns timescale benches.

---
 rtl/sum1b_primitive_core.sv | 65 ++++++
 tb/tb_sum1b_primitive_core.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sum1b_primitive_core.sv
// 1-bit full adder built from gate primitives, with a register stage and an
// optional bit-serial mode that recirculates the registered carry.
module sum1b_primitive_core (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic Ci,
  input  logic ser_en,
  input  logic clr,
  output logic S,
  output logic Cout,
  output logic S_q,
  output logic Cout_q,
  output logic valid_q
);

  logic r_sumQ;
  logic r_coutQ;
  logic r_carryQ;
  logic r_validQ;

  wire w_ciEff;
  wire w_aXorB;
  wire w_sum;
  wire w_aAndB;
  wire w_aAndCi;
  wire w_bAndCi;
  wire w_cout;

  // Serial mode takes the carry from the previous bit instead of the port.
  assign w_ciEff = ser_en ? r_carryQ : Ci;

  xor u_xorAb  (w_aXorB, A, B);
  xor u_xorSum (w_sum, w_aXorB, w_ciEff);

  and u_andAb  (w_aAndB, A, B);
  and u_andACi (w_aAndCi, A, w_ciEff);
  and u_andBCi (w_bAndCi, B, w_ciEff);
  or  u_orCout (w_cout, w_aAndB, w_aAndCi, w_bAndCi);

  assign S    = w_sum;
  assign Cout = w_cout;

  // clr only clears the recirculated carry; the result registers still
  // capture the current combinational values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sumQ   <= 1'b0;
      r_coutQ  <= 1'b0;
      r_carryQ <= 1'b0;
      r_validQ <= 1'b0;
    end else begin
      r_sumQ   <= w_sum;
      r_coutQ  <= w_cout;
      r_carryQ <= clr ? 1'b0 : w_cout;
      r_validQ <= 1'b1;
    end
  end

  assign S_q     = r_sumQ;
  assign Cout_q  = r_coutQ;
  assign valid_q = r_validQ;

endmodule

// File: tb/tb_sum1b_primitive_core.sv
// Self-checking bench for sum1b_primitive_core: directed scenarios followed
// by random vectors checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_sum1b_primitive_core;

  logic clk = 1'b0;
  logic clkRun = 1'b0;
  logic rstN, a, b, ci, serEn, clr;
  logic s, cout, sQ, coutQ, validQ;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: carry kept between bits plus the registered outputs.
  logic mCarry = 1'b0, mSq = 1'b0, mCq = 1'b0, mValid = 1'b0;

  sum1b_primitive_core dut (
    .clk(clk), .rst_n(rstN), .A(a), .B(b), .Ci(ci), .ser_en(serEn), .clr(clr),
    .S(s), .Cout(cout), .S_q(sQ), .Cout_q(coutQ), .valid_q(validQ)
  );

  always begin
    #5;
    if (clkRun) clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [1:0] addBits(input logic x, input logic y, input logic z);
    int t;
    t = int'(x) + int'(y) + int'(z);
    return t[1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkComb(input string tag);
    logic [1:0] r;
    r = addBits(a, b, serEn ? mCarry : ci);
    checkOutput({tag, ".S"}, s, r[0]);
    checkOutput({tag, ".Cout"}, cout, r[1]);
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, ".S_q"}, sQ, mSq);
    checkOutput({tag, ".Cout_q"}, coutQ, mCq);
    checkOutput({tag, ".valid_q"}, validQ, mValid);
  endtask

  task automatic modelReset();
    mCarry = 1'b0; mSq = 1'b0; mCq = 1'b0; mValid = 1'b0;
  endtask

  // Advance one rising edge, updating the model from the pre-edge inputs.
  task automatic applyStimulus();
    logic [1:0] r;
    r = addBits(a, b, serEn ? mCarry : ci);
    @(posedge clk);
    if (rstN) begin
      mSq = r[0]; mCq = r[1]; mCarry = clr ? 1'b0 : r[1]; mValid = 1'b1;
    end
    #1;
  endtask

  initial begin
    logic [7:0] sTable, cTable;
    logic [3:0] opA, opB, sqSeq;
    sTable = 8'b1001_0110;
    cTable = 8'b1110_1000;
    opA = 4'b0111; opB = 4'b0011; sqSeq = 4'b1010;

    // Truth table with reset held and no clock.
    rstN = 1'b0; serEn = 1'b0; clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      {a, b, ci} = 3'(i);
      #20;
      checkOutput($sformatf("tt%0d.S", i), s, sTable[i]);
      checkOutput($sformatf("tt%0d.Cout", i), cout, cTable[i]);
    end
    checkRegs("resetState");

    // Register capture.
    rstN = 1'b1; a = 1'b1; b = 1'b1; ci = 1'b0;
    clkRun = 1'b1;
    applyStimulus();
    checkOutput("capture.S_q", sQ, 1'b0);
    checkOutput("capture.Cout_q", coutQ, 1'b1);
    checkOutput("capture.valid_q", validQ, 1'b1);

    // Serial add 0111 + 0011, LSB first, after a clr cycle.
    a = 1'b0; b = 1'b0; ci = 1'b0; clr = 1'b1;
    applyStimulus();
    clr = 1'b0; serEn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = opA[i]; b = opB[i];
      #1;
      checkComb($sformatf("serial%0d", i));
      applyStimulus();
      checkOutput($sformatf("serial%0d.S_q", i), sQ, sqSeq[i]);
      checkRegs($sformatf("serial%0d", i));
    end
    checkOutput("serialFinal.Cout_q", coutQ, 1'b0);

    // Pre-load carry, then serial 1 + 0 + carry.
    serEn = 1'b0; a = 1'b1; b = 1'b1; ci = 1'b0;
    applyStimulus();
    serEn = 1'b1; a = 1'b1; b = 1'b0;
    #1;
    checkOutput("chain.S", s, 1'b0);
    checkOutput("chain.Cout", cout, 1'b1);

    // Asynchronous reset between edges.
    checkOutput("preReset.Cout_q", coutQ, 1'b1);
    #2 rstN = 1'b0;
    modelReset();
    #1;
    checkOutput("asyncReset.S_q", sQ, 1'b0);
    checkOutput("asyncReset.Cout_q", coutQ, 1'b0);
    checkOutput("asyncReset.valid_q", validQ, 1'b0);
    checkOutput("asyncReset.S", s, 1'b1);
    b = 1'b1;
    #1;
    checkOutput("asyncReset.track.S", s, 1'b0);
    checkOutput("asyncReset.track.Cout", cout, 1'b1);
    applyStimulus();
    checkRegs("heldReset");
    rstN = 1'b1;

    // clr priority over the recirculated carry.
    a = 1'b1; b = 1'b1; clr = 1'b1; serEn = 1'b1;
    applyStimulus();
    checkOutput("clrPrio.Cout_q", coutQ, 1'b1);
    clr = 1'b0; a = 1'b0; b = 1'b0;
    #1;
    checkOutput("clrPrio.S", s, 1'b0);
    checkOutput("clrPrio.Cout", cout, 1'b0);

    // Random vectors with occasional asynchronous reset pulses.
    for (int i = 0; i < 300; i++) begin
      a = 1'($urandom); b = 1'($urandom); ci = 1'($urandom);
      serEn = 1'($urandom); clr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin
        rstN = 1'b0;
        modelReset();
        #1;
        checkRegs($sformatf("rnd%0d.reset", i));
        rstN = 1'b1;
      end
      #1;
      checkComb($sformatf("rnd%0d", i));
      applyStimulus();
      checkRegs($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
